// File: rtl/maze_pkg.sv
// Shared definitions for the rat-to-maze memory protocol: maze geometry,
// responder state names and cell polarity.
package maze_pkg;

    localparam int AW = 4;
    localparam int N  = 2 ** AW;

    typedef enum logic [1:0] {
        LOAD  = 2'd0,
        SERVE = 2'd1,
        CLEAR = 2'd2
    } maze_state_t;

    localparam logic BLOCKED = 1'b1;
    localparam logic OPEN    = 1'b0;

endpackage

// File: rtl/maze_memory_responder_if.sv
// Rat/loader <-> maze responder signal bundle. The master drives requests
// and load rows; the slave (responder) returns read data and ready flags.
interface maze_memory_responder_if;

    logic                     Din;
    logic                     RD;
    logic                     WR;
    logic [maze_pkg::AW-1:0]  X;
    logic [maze_pkg::AW-1:0]  Y;
    logic                     Dout;
    logic                     Ready;
    logic                     LdValid;
    logic [maze_pkg::N-1:0]   LdRow;
    logic                     LdReady;
    logic                     Clear;

    modport master (
        output Din, RD, WR, X, Y, LdValid, LdRow, Clear,
        input  Dout, Ready, LdReady
    );

    modport slave (
        input  Din, RD, WR, X, Y, LdValid, LdRow, Clear,
        output Dout, Ready, LdReady
    );

endinterface

// File: rtl/maze_bitplane.sv
// N x N single-bit register array with a whole-row write/clear port,
// a single-cell write port and an asynchronous single-cell read port.
module maze_bitplane
    import maze_pkg::*;
(
    input  logic          i_clk,
    input  logic          i_row_we,
    input  logic          i_row_clr,
    input  logic [AW-1:0] i_row_addr,
    input  logic [N-1:0]  i_row_data,
    input  logic          i_bit_we,
    input  logic [AW-1:0] i_bit_x,
    input  logic [AW-1:0] i_bit_y,
    input  logic          i_bit_d,
    input  logic [AW-1:0] i_rd_x,
    input  logic [AW-1:0] i_rd_y,
    output logic          o_rd_bit
);

    logic [N-1:0] r_mem [N];

    // Row operations win over the cell port; the responder never issues both.
    always_ff @(posedge i_clk) begin
        if (i_row_we) begin
            r_mem[i_row_addr] <= i_row_data;
        end else if (i_row_clr) begin
            r_mem[i_row_addr] <= '0;
        end else if (i_bit_we) begin
            r_mem[i_bit_y][i_bit_x] <= i_bit_d;
        end
    end

    assign o_rd_bit = r_mem[i_rd_y][i_rd_x];

endmodule

// File: rtl/maze_memory_responder.sv
// Maze memory responder: wall plane loaded row by row, mark plane written
// by the rat, reads return wall | mark with one cycle of latency.
module maze_memory_responder
    import maze_pkg::*;
(
    input  logic                    CLK,
    input  logic                    RST,
    maze_memory_responder_if.slave  bus
);

    localparam logic [1:0] ST_LOAD  = LOAD;
    localparam logic [1:0] ST_SERVE = SERVE;
    localparam logic [1:0] ST_CLEAR = CLEAR;
    localparam logic [AW-1:0] LAST_ROW = AW'(N - 1);

    logic [1:0]    r_state;
    logic [AW-1:0] r_row;
    logic          r_dout;

    logic w_in_load;
    logic w_in_serve;
    logic w_in_clear;
    logic w_load_acc;
    logic w_rd_req;
    logic w_wr_req;
    logic w_wall_bit;
    logic w_mark_bit;
    logic w_rd_bit;

    assign w_in_load  = (r_state == ST_LOAD);
    assign w_in_serve = (r_state == ST_SERVE);
    assign w_in_clear = (r_state == ST_CLEAR);
    assign w_load_acc = w_in_load & bus.LdValid;

    // Clear pre-empts any read or write presented in the same cycle.
    assign w_rd_req   = w_in_serve & bus.RD & ~bus.Clear;
    assign w_wr_req   = w_in_serve & bus.WR & ~bus.Clear;
    assign w_rd_bit   = w_wall_bit | w_mark_bit;

    maze_bitplane u_wall (
        .i_clk      (CLK),
        .i_row_we   (w_load_acc),
        .i_row_clr  (1'b0),
        .i_row_addr (r_row),
        .i_row_data (bus.LdRow),
        .i_bit_we   (1'b0),
        .i_bit_x    ('0),
        .i_bit_y    ('0),
        .i_bit_d    (1'b0),
        .i_rd_x     (bus.X),
        .i_rd_y     (bus.Y),
        .o_rd_bit   (w_wall_bit)
    );

    // Loading a row also wipes its marks so a fresh maze starts unvisited.
    maze_bitplane u_mark (
        .i_clk      (CLK),
        .i_row_we   (1'b0),
        .i_row_clr  (w_load_acc | w_in_clear),
        .i_row_addr (r_row),
        .i_row_data ('0),
        .i_bit_we   (w_wr_req),
        .i_bit_x    (bus.X),
        .i_bit_y    (bus.Y),
        .i_bit_d    (bus.Din),
        .i_rd_x     (bus.X),
        .i_rd_y     (bus.Y),
        .o_rd_bit   (w_mark_bit)
    );

    always_ff @(posedge CLK) begin
        if (RST) begin
            r_state <= ST_LOAD;
            r_row   <= '0;
            r_dout  <= 1'b0;
        end else begin
            case (r_state)
                ST_LOAD: begin
                    r_dout <= 1'b0;
                    if (bus.LdValid) begin
                        r_row <= r_row + AW'(1);
                        if (r_row == LAST_ROW) begin
                            r_state <= ST_SERVE;
                        end
                    end
                end
                ST_SERVE: begin
                    if (bus.Clear) begin
                        r_state <= ST_CLEAR;
                        r_row   <= '0;
                    end else if (w_rd_req) begin
                        r_dout <= w_rd_bit;
                    end
                end
                ST_CLEAR: begin
                    r_row <= r_row + AW'(1);
                    if (r_row == LAST_ROW) begin
                        r_state <= ST_SERVE;
                    end
                end
                default: begin
                    r_state <= ST_LOAD;
                    r_row   <= '0;
                    r_dout  <= 1'b0;
                end
            endcase
        end
    end

    assign bus.Dout    = r_dout;
    assign bus.Ready   = w_in_serve;
    assign bus.LdReady = w_in_load;

endmodule
